// File: rtl/fp8_e4m3_mul_pipe.sv
// Two-stage pipelined FP8 E4M3 multiplier with valid/ready handshake.
// Stage 1 unpacks and multiplies significands; stage 2 normalizes, rounds (RNE) and packs.
module fp8_e4m3_mul_pipe #(
  parameter bit SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic [3:0] flags
);

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned SIG_W  = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned BE_W   = 7;

  // Returns {unbiased exponent, 1.fff significand}; subnormals are normalized here.
  function automatic logic [EXP_W+SIG_W-1:0] unpack_op(input logic [6:0] em);
    logic [EXP_W+SIG_W-1:0] r;
    if (em[6:3] != 4'd0)
      r = {EXP_W'({2'b00, em[6:3]}) - EXP_W'(7), 1'b1, em[2:0]};
    else if (em[2])
      r = {EXP_W'(-7), 1'b1, em[1:0], 1'b0};
    else if (em[1])
      r = {EXP_W'(-8), 1'b1, em[0], 2'b00};
    else
      r = {EXP_W'(-9), 4'b1000};
    return r;
  endfunction

  logic                    adv;
  logic                    s1_valid, s1_sign, s1_nan, s1_zero;
  logic [EXP_W-1:0]        s1_exp;
  logic [PROD_W-1:0]       s1_prod;
  logic                    s2_valid;

  logic [EXP_W+SIG_W-1:0]  ua_c, ub_c;
  logic [6:0]              norm_c;
  logic                    guard_c, sticky_c, rup_c, carry_c;
  logic [2:0]              mant_c;
  logic signed [BE_W-1:0]  be_c;
  logic [7:0]              res_c;
  logic [3:0]              flg_c;

  assign adv       = !s2_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = s2_valid;
  assign ua_c      = unpack_op(a[6:0]);
  assign ub_c      = unpack_op(b[6:0]);

  // Stage 1: sign, specials, exponent sum and 4x4 significand product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= a[7] ^ b[7];
      s1_nan   <= (a[6:0] == 7'h7F) | (b[6:0] == 7'h7F);
      s1_zero  <= (a[6:0] == 7'h00) | (b[6:0] == 7'h00);
      s1_exp   <= ua_c[EXP_W+SIG_W-1:SIG_W] + ub_c[EXP_W+SIG_W-1:SIG_W];
      s1_prod  <= PROD_W'(ua_c[SIG_W-1:0]) * PROD_W'(ub_c[SIG_W-1:0]);
    end
  end

  // Stage 2 datapath: normalize, round-to-nearest-even, classify and pack
  always_comb begin
    norm_c   = s1_prod[7] ? s1_prod[6:0] : {s1_prod[5:0], 1'b0};
    guard_c  = norm_c[3];
    sticky_c = |norm_c[2:0];
    rup_c    = guard_c & (sticky_c | norm_c[4]);
    mant_c   = norm_c[6:4] + 3'(rup_c);
    carry_c  = rup_c & (&norm_c[6:4]);
    be_c     = {s1_exp[EXP_W-1], s1_exp} + BE_W'(7) + BE_W'(s1_prod[7]) + BE_W'(carry_c);
    res_c    = {s1_sign, 7'd0};
    flg_c    = 4'b0000;
    if (s1_nan) begin
      res_c = 8'h7F;
      flg_c = 4'b1000;
    end else if (s1_zero) begin
      res_c = {s1_sign, 7'd0};
    end else if (be_c > 7'sd15 || (be_c == 7'sd15 && mant_c == 3'b111)) begin
      res_c = SATURATE ? {s1_sign, 7'h7E} : 8'h7F;
      flg_c = SATURATE ? 4'b0101 : 4'b1101;
    end else if (be_c < 7'sd1) begin
      flg_c = 4'b0011;
    end else begin
      res_c = {s1_sign, be_c[3:0], mant_c};
      flg_c = {3'b000, guard_c | sticky_c};
    end
  end

  // Stage 2 register: output holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= 8'h00;
      flags    <= 4'h0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_c;
        flags  <= flg_c;
      end
    end
  end

endmodule

// File: tb/tb_fp8_e4m3_mul_pipe.sv
// Self-checking bench: real-valued E4M3 reference model, scoreboard queues per DUT,
// directed, streaming, backpressure, reset and randomized traffic.
module tb_fp8_e4m3_mul_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [7:0] a, b;
  logic       rdy_s, ov_s, rdy_n, ov_n;
  logic [7:0] res_s, res_n;
  logic [3:0] flg_s, flg_n;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int first_out;
  logic [11:0] q_s[$];
  logic [11:0] q_n[$];
  logic       ov_seen, rdy_seen;
  logic [7:0] res_seen;

  always #5 clk = ~clk;

  fp8_e4m3_mul_pipe #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .a(a), .b(b),
    .out_valid(ov_s), .out_ready(out_ready), .result(res_s), .flags(flg_s));

  fp8_e4m3_mul_pipe #(.SATURATE(1'b0)) u_nan (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_n), .a(a), .b(b),
    .out_valid(ov_n), .out_ready(out_ready), .result(res_n), .flags(flg_n));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real decode(input logic [6:0] em);
    int e = int'(em[6:3]);
    int m = int'(em[2:0]);
    if (e == 0) return (real'(m) / 8.0) * pow2(-6);
    return (1.0 + real'(m) / 8.0) * pow2(e - 7);
  endfunction

  // Reference: exact real product, rounded RNE to 3 fraction bits -> {flags, result}
  function automatic logic [11:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input bit sat);
    logic s;
    real  v, q, frac;
    int   e, r, be;
    s = x[7] ^ y[7];
    if (x[6:0] == 7'h7F || y[6:0] == 7'h7F) return {4'b1000, 8'h7F};
    if (x[6:0] == 7'h00 || y[6:0] == 7'h00) return {4'b0000, s, 7'h00};
    v = decode(x[6:0]) * decode(y[6:0]);
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    q = v * 8.0;
    r = $rtoi(q);
    frac = q - real'(r);
    if (frac > 0.5 || (frac == 0.5 && (r % 2) == 1)) r++;
    if (r == 16) begin r = 8; e++; end
    be = e + 7;
    if (be > 15 || (be == 15 && r == 15))
      return sat ? {4'b0101, s, 7'h7E} : {4'b1101, 8'h7F};
    if (be < 1) return {4'b0011, s, 7'h00};
    return {3'b000, frac != 0.0, s, 4'(be), 3'(r - 8)};
  endfunction

  // One clock: drive at negedge, sample handshake, update scoreboards
  task automatic cycle(input bit iv, input logic [7:0] va, input logic [7:0] vb, input bit ordy);
    logic [11:0] e;
    @(negedge clk);
    in_valid = iv; a = va; b = vb; out_ready = ordy;
    #1;
    ov_seen = ov_s; rdy_seen = rdy_s; res_seen = res_s;
    if (iv && rdy_s) q_s.push_back(ref_mul(va, vb, 1'b1));
    if (iv && rdy_n) q_n.push_back(ref_mul(va, vb, 1'b0));
    if (ov_s && ordy) begin
      n_out++;
      if (q_s.size() == 0) check("sat_extra_out", 1, 0);
      else begin
        e = q_s.pop_front();
        check("sat_result", res_s, e[7:0]);
        check("sat_flags", flg_s, e[11:8]);
      end
    end
    if (ov_n && ordy) begin
      if (q_n.size() == 0) check("nan_extra_out", 1, 0);
      else begin
        e = q_n.pop_front();
        check("nan_result", res_n, e[7:0]);
        check("nan_flags", flg_n, e[11:8]);
      end
    end
  endtask

  logic [15:0] dir [11] = '{16'h3838, 16'h3C3C, 16'hBC40, 16'h3939, 16'h393C, 16'h7F38,
                            16'h8040, 16'h7E40, 16'h0808, 16'h0160, 16'h7E38};

  function automatic logic [7:0] rnd_op();
    logic [7:0] sp [6] = '{8'h00, 8'h80, 8'h7F, 8'h7E, 8'h08, 8'h01};
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check("rst_out_valid", {ov_s, ov_n}, 2'b00);
    check("rst_result", {res_s, res_n}, 16'h0000);
    check("rst_flags", {flg_s, flg_n}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_in_ready", {rdy_s, rdy_n}, 2'b11);

    // Latency: presented in cycle 0, visible in cycle 2
    cycle(1'b1, 8'h38, 8'h38, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b0);
    check("lat_cycle1_valid", ov_seen, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    check("lat_cycle2_valid", ov_seen, 1'b1);

    // Directed vectors, back to back
    foreach (dir[i]) cycle(1'b1, dir[i][15:8], dir[i][7:0], 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Streaming: 6 accepts -> 6 results with no gaps
    n_out = 0; first_out = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(i < 6, rnd_op(), rnd_op(), 1'b1);
      if (first_out < 0 && n_out > 0) first_out = i;
    end
    check("stream_count", n_out, 6);
    check("stream_first", first_out, 2);

    // Backpressure: fill both stages, then hold
    cycle(1'b1, 8'h3C, 8'h3C, 1'b0);
    cycle(1'b1, 8'h39, 8'h3C, 1'b0);
    cycle(1'b1, 8'h40, 8'h40, 1'b0);
    check("bp_in_ready_low", rdy_seen, 1'b0);
    check("bp_held_result", res_seen, 8'h41);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rnd_op(), rnd_op(), 1'b0);
      check("bp_hold_valid", ov_seen, 1'b1);
      check("bp_hold_result", res_seen, 8'h41);
    end
    repeat (4) cycle(1'b0, 8'h00, 8'h00, 1'b1);
    check("bp_drained", q_s.size() + q_n.size(), 0);

    // Reset with two operations in flight
    cycle(1'b1, 8'h3C, 8'h3C, 1'b1);
    cycle(1'b1, 8'h39, 8'h39, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {ov_s, ov_n}, 2'b00);
    check("midrst_result", {res_s, res_n}, 16'h0000);
    check("midrst_flags", {flg_s, flg_n}, 8'h00);
    q_s.delete(); q_n.delete();
    @(negedge clk); rst_n = 1'b1;
    #1 check("midrst_in_ready", {rdy_s, rdy_n}, 2'b11);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      if (ov_seen) cnt++;
    end
    check("midrst_no_stale", cnt, 0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), $urandom_range(0, 3) != 0);

    cnt = 0;
    while ((q_s.size() != 0 || q_n.size() != 0) && cnt < 20) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
      cnt++;
    end
    check("final_drain", q_s.size() + q_n.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
